mpsoc_wb_slave_ram: RTL
=======================

MPSOC_WB_SLAVE_RAM -- requirements
Module: mpsoc_wb_slave_ram

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 256, memory size in DW-bit words (power of 2).
REQ-004 SHALL have parameter WAIT_STATES, default 0, wait cycles before first ack of each cycle.
REQ-005 SHALL have ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type (000 classic, 001 const, 010 incr, 111 end).
- wb_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16).
- wb_dat_o  out  DW  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- wb_rty_o  out  1  retry, constant 0.

Function
REQ-006 SHALL use a word index of adr[ADR_LSB +: log2(DEPTH)], where ADR_LSB = log2(DW/8).
REQ-007 SHALL implement FSM states IDLE, WAIT, BURST; all outputs SHALL be registered.
REQ-008 In IDLE, when cyc&stb&!ack, SHALL latch address, cti and bte, then go to WAIT if WAIT_STATES>0, else assert ack next cycle.
REQ-009 WAIT SHALL count exactly WAIT_STATES cycles and then assert ack for one cycle; the first-beat latency from stb sampled to ack is 1+WAIT_STATES cycles.
REQ-010 For a classic access (cti=000 or 111), ack SHALL be high for exactly one cycle, then the FSM returns to IDLE; back-to-back classic accesses therefore yield ack on at most every other cycle.
REQ-011 A write beat SHALL update only the bytes enabled by sel, using wb_dat_i at the ack clock edge; unselected bytes SHALL be unchanged.
REQ-012 Read data SHALL be presented on wb_dat_o in the same cycle as ack; otherwise wb_dat_o SHALL hold its last value.
REQ-013 For a burst (first beat cti=001 or 010), after the first ack the FSM SHALL enter BURST and keep ack high every cycle while cyc&stb, with zero wait states, using an internally predicted address.
REQ-014 Next address SHALL be unchanged for cti=001; for cti=010 it SHALL increment by one word, with bte wrap inside aligned 4, 8 or 16-word blocks (linear wraps modulo DEPTH).
REQ-015 A beat acked with cti=111 SHALL end the burst: ack low next cycle, FSM to IDLE.
REQ-016 If cyc or stb is low while in WAIT or BURST, SHALL drop ack next cycle, perform no write, and return to IDLE.
REQ-017 Out-of-range handling SHALL follow REQ-023/024; err and ack SHALL never be high together.

Reset
REQ-018 On wb_rst_i high, ack, err, rty and dat_o SHALL go to 0 immediately, FSM to IDLE, and the wait counter to 0.
REQ-019 Memory contents SHALL NOT be reset.
REQ-020 Reset mid-burst SHALL abort the burst without a write on that edge; after release, a new access starts from IDLE.

Configuration
REQ-021 Macro MPSOC_WB_SLAVE_RAM_ERR_EN SHALL select out-of-range behaviour.
REQ-022 Out-of-range is defined as any address bits above ADR_LSB+log2(DEPTH)-1 being nonzero.
REQ-023 With the macro defined, an out-of-range beat SHALL assert wb_err_o instead of ack, after the same latency, with no write; a burst SHALL terminate to IDLE after the error.
REQ-024 Without the macro, the upper address bits SHALL be ignored: address aliases modulo DEPTH, ack as normal, and wb_err_o tied 0.

Verification
REQ-025 Reset, then classic write adr 0x10, dat 0xDEADBEEF, sel 0xF, then classic read adr 0x10 -> single ack each, read returns 0xDEADBEEF.
REQ-026 WAIT_STATES=3, classic read -> ack exactly 4 cycles after stb sampled.
REQ-027 Write 0xFFFFFFFF to adr 0x20, then write 0x00000000 with sel 0x3, then read -> 0xFFFF0000.
REQ-028 Incr wrap4 burst of 4 beats from adr 0x08, data 1,2,3,4, then read words 0x08,0x0C,0x00,0x04 -> 1,2,3,4; ack continuous for 4 cycles.
REQ-029 ERR_EN defined: access to adr 0x400 (DEPTH=256) -> wb_err_o 1 for one cycle, ack 0, memory unchanged; without ERR_EN -> ack, aliases to adr 0x000.
REQ-030 Assert reset during beat 2 of an 8-beat burst -> ack 0 immediately; after release, classic read adr 0x0 -> one normal ack.

Source files
------------

// File: rtl/mpsoc_wb_slave_ram.sv
// Wishbone registered-feedback RAM slave: classic cycles, constant/incrementing bursts, optional wait states.
// Define MPSOC_WB_SLAVE_RAM_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module mpsoc_wb_slave_ram #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int NB      = DW / 8;
  localparam int ADR_LSB = $clog2(NB);
  localparam int IW      = $clog2(DEPTH);
  localparam int CW      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, adr_idx, rd_idx, nxt_idx, inc_idx, wrap_msk;
  logic [2:0]    cti_q, cti_d;
  logic [1:0]    bte_q, bte_d;
  logic          oor_q, oor_d, oor_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] dat_q, dat_d, rd_word;
  logic          req, issue, issue_oor, issue_burst, wr_en;
  logic          adr_unused;

  function automatic logic is_burst(input logic [2:0] cti);
    return (cti == 3'b001) || (cti == 3'b010);
  endfunction

  assign req        = wb_cyc_i & wb_stb_i;
  assign adr_idx    = wb_adr_i[ADR_LSB +: IW];
  assign adr_unused = ^wb_adr_i;

`ifdef MPSOC_WB_SLAVE_RAM_ERR_EN
  assign oor_in = (wb_adr_i >> (ADR_LSB + IW)) != '0;
`else
  assign oor_in = 1'b0;
`endif

  // Burst address prediction: wrap boundaries come from bte, linear wraps at DEPTH.
  always_comb begin
    case (bte_q)
      2'b01:   wrap_msk = IW'(3);
      2'b10:   wrap_msk = IW'(7);
      2'b11:   wrap_msk = IW'(15);
      default: wrap_msk = '1;
    endcase
    inc_idx = idx_q + 1'b1;
    if (cti_q == 3'b010) nxt_idx = (idx_q & ~wrap_msk) | (inc_idx & wrap_msk);
    else                 nxt_idx = idx_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cti_d       = cti_q;
    bte_d       = bte_q;
    oor_d       = oor_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = dat_q;
    rd_idx      = idx_q;
    issue       = 1'b0;
    issue_oor   = oor_q;
    issue_burst = is_burst(cti_q);
    case (state_q)
      IDLE: begin
        if (req && !ack_q && !err_q) begin
          idx_d = adr_idx;
          cti_d = wb_cti_i;
          bte_d = wb_bte_i;
          oor_d = oor_in;
          cnt_d = '0;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            issue       = 1'b1;
            rd_idx      = adr_idx;
            issue_oor   = oor_in;
            issue_burst = is_burst(wb_cti_i);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(WAIT_STATES - 1)) begin
          issue = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BURST: begin
        // The beat currently acked carries cti; anything but const/incr closes the burst.
        if (!req || !is_burst(wb_cti_i)) begin
          state_d = IDLE;
        end else begin
          idx_d  = nxt_idx;
          rd_idx = nxt_idx;
          issue  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (issue_oor) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        ack_d   = 1'b1;
        dat_d   = rd_word;
        state_d = issue_burst ? BURST : IDLE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cti_q   <= '0;
      bte_q   <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      oor_q   <= oor_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // A beat's write lands on the edge that completes it: ack already high and the master still strobing.
  assign wr_en = ack_q & req & wb_we_i;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge wb_clk_i) begin
      if (wr_en && wb_sel_i[gi]) mem[idx_q] <= wb_dat_i[gi*8 +: 8];
    end
    assign rd_word[gi*8 +: 8] = mem[rd_idx];
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule
